// File: rtl/cas_fsk_player.sv
// cas_fsk_player
// Plays a cassette image from core memory into the PIA1 PA0 cassette input
// as CoCo/Dragon FSK audio. The player fetches bytes over a simple read
// handshake and sends each byte LSB first. Each bit is one full square
// cycle: '0' uses HALF0-cycle halves and '1' uses HALF1-cycle halves.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-low
//   motor     cassette motor relay (1 = run)
//   rewind    one-cycle pulse: tape position back to 0
//   load      image download in progress: holds the player idle at position 0
//   len       image length in bytes (0 = no tape)
//   rd_req    one-cycle read request for the byte at rd_addr
//   rd_addr   byte address, held stable until rd_valid
//   rd_data   read data, sampled when rd_valid is high
//   rd_valid  read complete
//   casdout   FSK audio bit to the core
//   playing   high while a bit is being emitted
//   pos       address of the byte currently being emitted
module cas_fsk_player #(
   parameter int unsigned HALF0     = 17898,
   parameter int unsigned HALF1     = 8949,
   parameter int unsigned MOTOR_DLY = 4295454
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        motor,
   input  logic        rewind,
   input  logic        load,
   input  logic [15:0] len,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   input  logic        rd_valid,
   output logic        casdout,
   output logic        playing,
   output logic [15:0] pos
);

   localparam logic [14:0] C_H0  = 15'(HALF0 - 1);
   localparam logic [14:0] C_H1  = 15'(HALF1 - 1);
   localparam logic [22:0] C_DLY = 23'(MOTOR_DLY - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_FETCH, S_HI, S_LO, S_PAUSE, S_END
   } state_t;

   state_t      r_state, w_state_nx;

   logic [15:0] r_pos;
   logic [15:0] r_rd_addr;
   logic        r_rd_req;
   logic [22:0] r_dly;
   logic [14:0] r_half;
   logic [7:0]  r_shift;
   logic [7:0]  r_nbuf;
   logic [2:0]  r_bitidx;
   logic        r_nvalid;     // r_nbuf holds the byte at r_rd_addr
   logic        r_pend;       // a read is outstanding
   logic        r_cur_valid;  // r_shift still holds unsent bits of byte r_pos
   logic        r_stop;       // motor dropped during the current bit

   logic        w_clear;
   logic        w_stop;
   logic        w_last_byte;
   logic        w_buf_avail;
   logic        w_half_zero;
   logic [7:0]  w_buf_data;
   logic [16:0] w_pos_p1;
   logic        w_take_buf;
   logic        w_next_in_byte;
   logic        w_pos_inc;
   logic        w_fetch_req;
   logic        w_pre_req;
   logic        w_half_ld;
   logic        w_half_bit;

   assign w_clear     = rewind | load;
   assign w_stop      = r_stop | ~motor;
   assign w_pos_p1    = {1'b0, r_pos} + 17'd1;
   assign w_last_byte = (w_pos_p1 >= {1'b0, len});
   assign w_half_zero = (r_half == '0);
   // A read returning in the same cycle it is needed is used directly.
   // This keeps byte boundaries gap-free.
   assign w_buf_avail = r_nvalid | (rd_valid & r_pend);
   assign w_buf_data  = r_nvalid ? r_nbuf : rd_data;
   // Prefetch the next byte while bit 0 of the current byte is playing.
   assign w_pre_req   = (r_state == S_HI) && (r_bitidx == 3'd0) && r_cur_valid &&
                        !r_pend && !r_nvalid && !w_last_byte;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx     = r_state;
      w_take_buf     = 1'b0;
      w_next_in_byte = 1'b0;
      w_pos_inc      = 1'b0;
      w_fetch_req    = 1'b0;
      w_half_ld      = 1'b0;
      w_half_bit     = r_shift[0];
      case (r_state)
         S_IDLE: begin
            if (motor && (len != '0) && (r_pos < len)) w_state_nx = S_SETTLE;
         end
         S_SETTLE: begin
            if (!motor) begin
               w_state_nx = S_IDLE;
            end else if (r_dly == '0) begin
               if (r_cur_valid) begin
                  w_state_nx = S_HI;
                  w_half_ld  = 1'b1;
               end else begin
                  w_state_nx = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (w_buf_avail) begin
               w_take_buf = 1'b1;
               w_half_bit = w_buf_data[0];
               w_half_ld  = 1'b1;
               w_state_nx = motor ? S_HI : S_PAUSE;
            end else if (!r_pend) begin
               w_fetch_req = 1'b1;
            end
         end
         S_HI: begin
            if (w_half_zero) begin
               w_state_nx = S_LO;
               w_half_ld  = 1'b1;
            end
         end
         S_LO: begin
            if (w_half_zero) begin
               if (r_bitidx == 3'd7) begin
                  w_pos_inc = 1'b1;
                  if (w_last_byte) begin
                     w_state_nx = S_END;
                  end else if (w_stop) begin
                     w_state_nx = S_PAUSE;
                  end else if (w_buf_avail) begin
                     w_take_buf = 1'b1;
                     w_half_bit = w_buf_data[0];
                     w_half_ld  = 1'b1;
                     w_state_nx = S_HI;
                  end else begin
                     w_state_nx = S_FETCH;
                  end
               end else begin
                  w_next_in_byte = 1'b1;
                  w_half_bit     = r_shift[1];
                  if (w_stop) begin
                     w_state_nx = S_PAUSE;
                  end else begin
                     w_half_ld  = 1'b1;
                     w_state_nx = S_HI;
                  end
               end
            end
         end
         S_PAUSE: begin
            if (motor) w_state_nx = S_SETTLE;
         end
         S_END: ;
         default: w_state_nx = S_IDLE;
      endcase
      if (w_clear) w_state_nx = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset || w_clear) begin
         r_pos       <= '0;
         r_rd_addr   <= '0;
         r_rd_req    <= 1'b0;
         r_dly       <= '0;
         r_half      <= '0;
         r_shift     <= '0;
         r_nbuf      <= '0;
         r_bitidx    <= '0;
         r_nvalid    <= 1'b0;
         r_pend      <= 1'b0;
         r_cur_valid <= 1'b0;
         r_stop      <= 1'b0;
      end else begin
         r_rd_req <= w_fetch_req | w_pre_req;
         if (w_fetch_req) begin
            r_rd_addr <= r_pos;
            r_pend    <= 1'b1;
         end else if (w_pre_req) begin
            r_rd_addr <= w_pos_p1[15:0];
            r_pend    <= 1'b1;
         end else if (rd_valid && r_pend) begin
            r_pend   <= 1'b0;
            r_nbuf   <= rd_data;
            r_nvalid <= 1'b1;
         end

         if (w_take_buf) begin
            r_nvalid    <= 1'b0;
            r_shift     <= w_buf_data;
            r_bitidx    <= '0;
            r_cur_valid <= 1'b1;
         end else if (w_next_in_byte) begin
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitidx <= r_bitidx + 3'd1;
         end

         if (w_pos_inc) begin
            r_pos <= r_pos + 16'd1;
            if (!w_take_buf) r_cur_valid <= 1'b0;
         end

         if ((r_state != S_SETTLE) && (w_state_nx == S_SETTLE)) r_dly <= C_DLY;
         else if ((r_state == S_SETTLE) && (r_dly != '0))      r_dly <= r_dly - 23'd1;

         if (w_half_ld)                                        r_half <= w_half_bit ? C_H1 : C_H0;
         else if (((r_state == S_HI) || (r_state == S_LO)) && !w_half_zero)
                                                               r_half <= r_half - 15'd1;

         r_stop <= ((r_state == S_HI) || (r_state == S_LO)) && w_stop;
      end
   end

   assign casdout = (r_state == S_HI);
   assign playing = (r_state == S_HI) || (r_state == S_LO);
   assign rd_req  = r_rd_req;
   assign rd_addr = r_rd_addr;
   assign pos     = r_pos;

endmodule
